detector_seq_ctrl: RTL and testbench

Controller that sequences the serial `0111110` sequence detector. It accepts parallel words over a valid/ready handshake and streams each word MSB-first onto the detector's `serIn`. It counts the detector's `w` pulses that belong to that word and returns the hit count over a second valid/ready handshake. It sits between a parallel producer/consumer and one `detector0111110` instance, and owns that detector's reset.

---
 rtl/det_ctrl_pkg.sv | 15 +
 rtl/det_piso.sv | 35 +++
 rtl/detector_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_detector_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/det_ctrl_pkg.sv
// Shared types and default sizing for the 0111110 detector sequencing controller.
package det_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } det_state_t;

    localparam int DET_WORD_W   = 16;
    localparam int DET_CNT_W    = 4;
    localparam int DET_MIN_WORD = 7;

endpackage

// File: rtl/det_piso.sv
// Parallel-load, MSB-first shift register with a registered serial output.
module det_piso #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] data,
    output logic         ser
);

    logic [W-1:0] shreg_r;
    logic         ser_r;

    // Load presents the MSB immediately; each shift exposes the next bit, zeros trail.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r <= {W{1'b0}};
            ser_r   <= 1'b0;
        end else if (load) begin
            shreg_r <= {data[W-2:0], 1'b0};
            ser_r   <= data[W-1];
        end else if (shift) begin
            shreg_r <= {shreg_r[W-2:0], 1'b0};
            ser_r   <= shreg_r[W-1];
        end else begin
            shreg_r <= shreg_r;
            ser_r   <= ser_r;
        end
    end

    assign ser = ser_r;

endmodule

// File: rtl/detector_seq_ctrl.sv
// Sequences one 0111110 detector: accepts a word, streams it MSB-first, counts hits.
// Build option: DET_CNT_SAT_EN makes the hit counter saturate instead of wrapping.
module detector_seq_ctrl
    import det_ctrl_pkg::*;
#(
    parameter int WORD_W = DET_WORD_W,
    parameter int CNT_W  = DET_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    input  logic [WORD_W-1:0] inData,
    output logic              inReady,
    output logic              serIn,
    output logic              detRst,
    input  logic              w,
    output logic              outValid,
    output logic [CNT_W-1:0]  hitCount,
    input  logic              outReady,
    output logic              busy
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    det_state_t       state_r;
    det_state_t       state_nxt_s;
    logic [BIT_W-1:0] bit_cnt_r;
    logic [CNT_W-1:0] hit_cnt_r;
    logic [CNT_W-1:0] hit_inc_s;
    logic             load_s;
    logic             shift_s;
    logic             sample_s;
    logic             in_ready_r;
    logic             det_rst_r;
    logic             out_valid_r;
    logic             busy_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (inValid) begin
                    state_nxt_s = SHIFT;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                shift_s = 1'b1;
                if (bit_cnt_r == LAST_BIT) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DRAIN: begin
                state_nxt_s = REPORT;
            end
            REPORT: begin
                if (outReady) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = REPORT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // w lags serIn by one cycle, so the first SHIFT cycle has nothing to sample yet.
    assign sample_s = ((state_r == SHIFT) && (bit_cnt_r != {BIT_W{1'b0}})) ||
                      (state_r == DRAIN);

`ifdef DET_CNT_SAT_EN
    assign hit_inc_s = (hit_cnt_r == {CNT_W{1'b1}}) ? hit_cnt_r : hit_cnt_r + CNT_W'(1);
`else
    assign hit_inc_s = hit_cnt_r + CNT_W'(1);
`endif

    // Bit and hit counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r <= {BIT_W{1'b0}};
            hit_cnt_r <= {CNT_W{1'b0}};
        end else if (load_s) begin
            bit_cnt_r <= {BIT_W{1'b0}};
            hit_cnt_r <= {CNT_W{1'b0}};
        end else begin
            bit_cnt_r <= (state_r == SHIFT) ? bit_cnt_r + BIT_W'(1) : bit_cnt_r;
            hit_cnt_r <= (sample_s && w) ? hit_inc_s : hit_cnt_r;
        end
    end

    // Status outputs registered from the next state so they never see inValid/outReady combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            det_rst_r   <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s == IDLE);
            det_rst_r   <= !((state_nxt_s == SHIFT) || (state_nxt_s == DRAIN));
            out_valid_r <= (state_nxt_s == REPORT);
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    det_piso #(
        .W (WORD_W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .shift (shift_s),
        .data  (inData),
        .ser   (serIn)
    );

    assign inReady  = in_ready_r;
    assign detRst   = det_rst_r;
    assign outValid = out_valid_r;
    assign hitCount = hit_cnt_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_detector_seq_ctrl.sv
// Self-checking bench for detector_seq_ctrl with a behavioural 0111110 detector model.
module tb_detector_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    // 16-bit instance
    logic        in_valid, in_ready, ser_in, det_rst, w, out_valid, out_ready, busy;
    logic [15:0] in_data;
    logic [3:0]  hit_count;
    // 32-bit, 2-bit counter instance
    logic        in_valid32, in_ready32, ser_in32, det_rst32, w32, out_valid32, out_ready32, busy32;
    logic [31:0] in_data32;
    logic [1:0]  hit_count32;

    detector_seq_ctrl #(.WORD_W(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .inValid(in_valid), .inData(in_data), .inReady(in_ready),
        .serIn(ser_in), .detRst(det_rst), .w(w), .outValid(out_valid),
        .hitCount(hit_count), .outReady(out_ready), .busy(busy));

    detector_seq_ctrl #(.WORD_W(32), .CNT_W(2)) dut32 (
        .clk(clk), .rst(rst), .inValid(in_valid32), .inData(in_data32), .inReady(in_ready32),
        .serIn(ser_in32), .detRst(det_rst32), .w(w32), .outValid(out_valid32),
        .hitCount(hit_count32), .outReady(out_ready32), .busy(busy32));

    // Detector model: last seven received bits compared with the pattern, one cycle after each bit.
    logic [6:0] hist_r, hist32_r;
    always @(posedge clk) begin
        hist_r   <= det_rst   ? 7'h7F : {hist_r[5:0], ser_in};
        hist32_r <= det_rst32 ? 7'h7F : {hist32_r[5:0], ser_in32};
        cyc      <= cyc + 1;
    end
    assign w   = (hist_r   == 7'b0111110);
    assign w32 = (hist32_r == 7'b0111110);

    function automatic int count_pat(input logic [31:0] word, input int width);
        int n = 0;
        for (int p = 0; p <= width - 7; p++)
            if (((word >> p) & 32'h7F) == 32'h3E) n++;
        return n;
    endfunction

    function automatic int expect_cnt(input int hits, input int cnt_w);
        int top;
        top = (1 << cnt_w) - 1;
`ifdef DET_CNT_SAT_EN
        return (hits > top) ? top : hits;
`else
        return hits % (1 << cnt_w);
`endif
    endfunction

    task automatic send16(input logic [15:0] word, input int hold, output int acc_cyc);
        int n;
        logic [3:0] exp;
        exp = 4'(expect_cnt(count_pat({16'h0000, word}, 16), 4));
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        acc_cyc = cyc;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: inReady=%b want 1", in_ready);
            return;
        end
        in_valid = 1'b1;
        in_data  = word;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (ser_in !== word[15-i] || det_rst !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL shift_bit%0d: serIn=%b detRst=%b outValid=%b busy=%b want %b 0 0 1",
                         i, ser_in, det_rst, out_valid, busy, word[15-i]);
            end
            @(negedge clk);
        end
        checks++;
        if (ser_in !== 1'b0 || det_rst !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: serIn=%b detRst=%b outValid=%b want 0 0 0", ser_in, det_rst, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || det_rst !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL report_latency: outValid=%b detRst=%b inReady=%b want 1 1 0", out_valid, det_rst, in_ready);
        end
        checks++;
        if (hit_count !== exp) begin
            errors++;
            $display("FAIL hit_count word=%h: got %0d want %0d", word, hit_count, exp);
        end
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || hit_count !== exp) begin
                errors++;
                $display("FAIL backpressure_hold%0d: outValid=%b hitCount=%0d want 1 %0d", h, out_valid, hit_count, exp);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release: inReady=%b outValid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic send32(input logic [31:0] word);
        logic [1:0] exp;
        exp = 2'(expect_cnt(count_pat(word, 32), 2));
        in_valid32 = 1'b1;
        in_data32  = word;
        @(negedge clk);
        in_valid32 = 1'b0;
        in_data32  = $urandom;
        repeat (32) @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b0 || busy32 !== 1'b1) begin
            errors++;
            $display("FAIL w32_drain: outValid=%b busy=%b want 0 1", out_valid32, busy32);
        end
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b1 || hit_count32 !== exp) begin
            errors++;
            $display("FAIL w32_count word=%h: outValid=%b hitCount=%0d want 1 %0d", word, out_valid32, hit_count32, exp);
        end
        out_ready32 = 1'b1;
        @(negedge clk);
        out_ready32 = 1'b0;
        checks++;
        if (in_ready32 !== 1'b1) begin
            errors++;
            $display("FAIL w32_release: inReady=%b want 1", in_ready32);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || hit_count !== 4'd0 || det_rst !== 1'b1 ||
            ser_in !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset16: inReady=%b outValid=%b hitCount=%0d detRst=%b serIn=%b busy=%b want 1 0 0 1 0 0",
                     in_ready, out_valid, hit_count, det_rst, ser_in, busy);
        end
        checks++;
        if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0 || hit_count32 !== 2'd0 || det_rst32 !== 1'b1 ||
            ser_in32 !== 1'b0 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL reset32: inReady=%b outValid=%b hitCount=%0d detRst=%b serIn=%b busy=%b want 1 0 0 1 0 0",
                     in_ready32, out_valid32, hit_count32, det_rst32, ser_in32, busy32);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int c;
        send16(16'h3E00, 0, c);
        send16(16'h7E00, 0, c);
    endtask

    task automatic test_back_to_back();
        int c0, c1;
        send16(16'h7DF0, 0, c0);
        send16(16'h0000, 0, c1);
        checks++;
        if (c1 - c0 !== 19) begin
            errors++;
            $display("FAIL b2b_period: got %0d cycles want 19", c1 - c0);
        end
    endtask

    task automatic test_backpressure();
        int c;
        send16(16'hBEFA, 10, c);
    endtask

    task automatic test_random();
        int c;
        logic [15:0] wd;
        int s;
        for (int k = 0; k < 8; k++) begin
            wd = 16'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                s  = $urandom_range(0, 9);
                wd = (wd & ~(16'h007F << s)) | (16'h003E << s);
            end
            send16(wd, $urandom_range(0, 3), c);
        end
    endtask

    task automatic test_overflow();
        send32(32'h7DF7DF7C);
        send32(32'h3E3E3E3E);
        send32($urandom);
    endtask

    task automatic test_midword_reset();
        bit seen;
        int c;
        in_valid = 1'b1;
        in_data  = 16'h7DF0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (ser_in !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_bit5: serIn=%b busy=%b want 1 1", ser_in, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || det_rst !== 1'b1 || out_valid !== 1'b0 ||
            ser_in !== 1'b0 || hit_count !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: inReady=%b busy=%b detRst=%b outValid=%b serIn=%b hitCount=%0d want 1 0 1 0 0 0",
                     in_ready, busy, det_rst, out_valid, ser_in, hit_count);
        end
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_no_report: outValid or busy rose after reset, want both 0");
        end
        send16(16'h3E00, 0, c);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = 16'h0000;
        out_ready   = 1'b0;
        in_valid32  = 1'b0;
        in_data32   = 32'h0;
        out_ready32 = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_overflow();
        test_midword_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
